// File: rtl/conv_pkg.sv
// Shared widths, window geometry and FSM state encoding for the 3x3 convolution engine.
// Pure definitions: no logic, no latency and no backpressure.
package conv_pkg;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    // 9 taps need 4 guard bits on top of one signed product.
    localparam int ACC_W  = DATA_W + COEF_W + 1 + 4;
    localparam int KSIZE  = 3;
    localparam int KTAPS  = KSIZE * KSIZE;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_MAC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef logic [DATA_W-1:0]        pixel_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/conv3x3_engine_if.sv
// Controller-facing bundle: compute handshake, BRAM row data, kernel writes and result.
// Wiring only: no latency; the controller must hold off starts and kernel writes while busy is high.
interface conv3x3_engine_if;
    import conv_pkg::*;

    logic        compute_conv;
    pixel_t      row0;
    pixel_t      row1;
    pixel_t      row2;
    logic        kernel_wr;
    logic [3:0]  kernel_addr;
    coef_t       kernel_data;
    logic        busy;
    logic        conv_done;
    acc_t        result;

    modport master (
        output compute_conv, row0, row1, row2, kernel_wr, kernel_addr, kernel_data,
        input  busy, conv_done, result
    );

    modport slave (
        input  compute_conv, row0, row1, row2, kernel_wr, kernel_addr, kernel_data,
        output busy, conv_done, result
    );
endinterface

// File: rtl/conv_mac.sv
// One signed multiply-accumulate per enabled cycle; sum is the combinational acc + current product.
// Latency 1 cycle into the accumulator; no backpressure, clr has priority over en.
module conv_mac
    import conv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   en,
    input  pixel_t pixel,
    input  coef_t  coef,
    output acc_t   sum
);
    logic signed [DATA_W:0]        pixel_s;
    logic signed [DATA_W+COEF_W:0] prod;
    acc_t                          prod_ext;
    acc_t                          acc;

    // Pixels are unsigned, so a zero MSB keeps them positive in the signed multiply.
    assign pixel_s  = {1'b0, pixel};
    assign prod     = pixel_s * coef;
    assign prod_ext = {{(ACC_W-DATA_W-COEF_W-1){prod[DATA_W+COEF_W]}}, prod};
    assign sum      = acc + prod_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end
endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 window capture from three BRAM rows, then 9 serial MACs against a stored kernel.
// Done pulses 12 edges after the accepting edge; starts and kernel writes are ignored while busy.
module conv3x3_engine
    import conv_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    conv3x3_engine_if.slave    bus
);
    logic [1:0] state;
    logic [1:0] col_cnt;
    logic [3:0] mac_idx;
    pixel_t     win  [KTAPS];
    coef_t      coef [KTAPS];
    logic       start;
    logic       last_tap;
    pixel_t     tap_pixel;
    coef_t      tap_coef;
    acc_t       mac_sum;

    assign start    = (state == ST_IDLE) && bus.compute_conv;
    assign last_tap = (mac_idx == 4'(KTAPS - 1));
    assign bus.busy = (state != ST_IDLE);

    always_comb begin
        tap_pixel = '0;
        tap_coef  = '0;
        for (int k = 0; k < KTAPS; k++) begin
            if (mac_idx == 4'(k)) begin
                tap_pixel = win[k];
                tap_coef  = coef[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            col_cnt       <= '0;
            mac_idx       <= '0;
            bus.conv_done <= 1'b0;
            bus.result    <= '0;
        end else begin
            bus.conv_done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state   <= ST_LOAD;
                    col_cnt <= '0;
                    mac_idx <= '0;
                end
                ST_LOAD: begin
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'(KSIZE - 1))
                        state <= ST_MAC;
                end
                ST_MAC: begin
                    mac_idx <= mac_idx + 4'd1;
                    if (last_tap) begin
                        bus.result    <= mac_sum;
                        bus.conv_done <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Row data arrives one cycle after the controller's address, i.e. one column per LOAD cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < KTAPS; k++)
                win[k] <= '0;
        end else if (state == ST_LOAD) begin
            for (int c = 0; c < KSIZE; c++) begin
                if (col_cnt == 2'(c)) begin
                    win[c]           <= bus.row0;
                    win[KSIZE + c]   <= bus.row1;
                    win[2*KSIZE + c] <= bus.row2;
                end
            end
        end
    end

    // Addresses 9..15 match no entry and fall through.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < KTAPS; k++)
                coef[k] <= '0;
        end else if (bus.kernel_wr && (state == ST_IDLE)) begin
            for (int k = 0; k < KTAPS; k++) begin
                if (bus.kernel_addr == 4'(k))
                    coef[k] <= bus.kernel_data;
            end
        end
    end

    conv_mac u_mac (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (start),
        .en    (state == ST_MAC),
        .pixel (tap_pixel),
        .coef  (tap_coef),
        .sum   (mac_sum)
    );
endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: a timing/result model checked every cycle,
// plus literal results and latencies for each scenario.
module tb_conv3x3_engine;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv3x3_engine_if bus();

    conv3x3_engine dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Model: kernel contents, window data for a run, start edge and results.
    int mk [KTAPS];
    int data [3][3];
    int start_edge = -1;
    int run_res    = 0;
    int held       = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_busy(input int e);
        return (start_edge >= 0 && e >= start_edge && e <= start_edge + 12) ? 1 : 0;
    endfunction

    function automatic int exp_done(input int e);
        return (start_edge >= 0 && e == start_edge + 12) ? 1 : 0;
    endfunction

    function automatic int exp_res(input int e);
        return (start_edge >= 0 && e >= start_edge + 12) ? run_res : held;
    endfunction

    function automatic int model_sum();
        int s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += data[r][c] * mk[3*r + c];
        return s;
    endfunction

    always @(negedge clk) begin
        chk("cyc_busy",   int'(bus.busy),      exp_busy(cyc));
        chk("cyc_done",   int'(bus.conv_done), exp_done(cyc));
        chk("cyc_result", int'(bus.result),    exp_res(cyc));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        start_edge = -1;
        run_res    = 0;
        held       = 0;
        for (int k = 0; k < KTAPS; k++) mk[k] = 0;
    endtask

    task automatic kwrite(input int addr, input int val);
        bus.kernel_wr   = 1'b1;
        bus.kernel_addr = 4'(addr);
        bus.kernel_data = 8'(val);
        step();
        bus.kernel_wr = 1'b0;
        if (exp_busy(cyc - 1) == 0 && addr < KTAPS) mk[addr] = val;
    endtask

    task automatic launch(input bit keep, input bit do_wr, input int waddr, input int wval);
        bus.compute_conv = 1'b1;
        if (do_wr) begin
            bus.kernel_wr   = 1'b1;
            bus.kernel_addr = 4'(waddr);
            bus.kernel_data = 8'(wval);
        end
        step();
        bus.kernel_wr = 1'b0;
        if (do_wr && waddr < KTAPS) mk[waddr] = wval;
        if (!keep) bus.compute_conv = 1'b0;
        if (start_edge >= 0) held = run_res;
        start_edge = cyc;
        run_res    = model_sum();
        for (int c = 0; c < 3; c++) begin
            bus.row0 = 8'(data[0][c]);
            bus.row1 = 8'(data[1][c]);
            bus.row2 = 8'(data[2][c]);
            step();
        end
        bus.row0 = '0;
        bus.row1 = '0;
        bus.row2 = '0;
    endtask

    task automatic wait_done(input string name, output int d_edge);
        d_edge = -1;
        for (int i = 0; i < 30 && d_edge < 0; i++) begin
            if (bus.conv_done) d_edge = cyc;
            else step();
        end
        if (d_edge < 0) begin
            chk({name, "_done_timeout"}, 0, 1);
        end else begin
            chk({name, "_latency"}, d_edge - start_edge, 12);
            step();
            chk({name, "_busy_after"}, int'(bus.busy), 0);
        end
    endtask

    task automatic run_expect(input string name, input int lit);
        int d;
        launch(1'b0, 1'b0, 0, 0);
        wait_done(name, d);
        chk({name, "_result"}, int'(bus.result), lit);
    endtask

    initial begin
        int d1, d2;
        bus.compute_conv = 1'b0;
        bus.row0 = '0; bus.row1 = '0; bus.row2 = '0;
        bus.kernel_wr = 1'b0; bus.kernel_addr = '0; bus.kernel_data = '0;
        model_reset();
        data = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_busy",   int'(bus.busy),      0);
        chk("reset_done",   int'(bus.conv_done), 0);
        chk("reset_result", int'(bus.result),    0);

        run_expect("zero_kernel", 0);

        kwrite(4, 1);
        run_expect("identity", 5);

        for (int k = 0; k < KTAPS; k++) kwrite(k, 1);
        launch(1'b1, 1'b0, 0, 0);
        wait_done("b2b_first", d1);
        chk("b2b_first_result", int'(bus.result), 45);
        launch(1'b0, 1'b0, 0, 0);
        wait_done("b2b_second", d2);
        chk("b2b_second_result", int'(bus.result), 45);
        chk("b2b_gap", d2 - d1, 14);

        data = '{'{255, 255, 255}, '{255, 255, 255}, '{255, 255, 255}};
        for (int k = 0; k < KTAPS; k++) kwrite(k, -128);
        run_expect("min_extreme", -293760);

        for (int k = 0; k < KTAPS - 1; k++) kwrite(k, 127);
        launch(1'b0, 1'b1, 8, 127);
        wait_done("max_extreme", d1);
        chk("max_extreme_result", int'(bus.result), 291465);

        data = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        kwrite(12, 9);
        launch(1'b0, 1'b0, 0, 0);
        kwrite(0, 7);
        bus.compute_conv = 1'b1;
        step();
        bus.compute_conv = 1'b0;
        kwrite(12, 3);
        wait_done("busy_writes", d1);
        chk("busy_writes_result", int'(bus.result), 5715);
        run_expect("busy_writes_rerun", 5715);

        launch(1'b0, 1'b0, 0, 0);
        repeat (3) step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrun_rst_busy",   int'(bus.busy),      0);
        chk("midrun_rst_done",   int'(bus.conv_done), 0);
        chk("midrun_rst_result", int'(bus.result),    0);
        repeat (2) step();
        rst = 1'b0;
        repeat (15) step();
        run_expect("after_reset", 0);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
